// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1/8N2 framing, LSB first, idle-high line.
// All outputs come straight from flops; a new frame is accepted only in IDLE.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] input_Byte,
  output logic       output_serial,
  output logic       active,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    CLEANUP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic             stop_idx_reg, stop_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             serial_reg, serial_next;
  logic             active_reg, active_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      serial_reg   <= 1'b1;
      active_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      shift_reg    <= shift_next;
      serial_reg   <= serial_next;
      active_reg   <= active_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic also computes the next output values, so the line
  // level registered here is exactly what appears during the next cycle.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    shift_next    = shift_reg;
    serial_next   = serial_reg;
    active_next   = active_reg;
    done_next     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        serial_next = 1'b1;
        active_next = 1'b0;
        if (start) begin
          state_next   = START_BIT;
          shift_next   = input_Byte;
          cnt_next     = '0;
          bit_idx_next = '0;
          serial_next  = 1'b0;
          active_next  = 1'b1;
        end
      end

      START_BIT: begin
        if (cnt_reg == CNT_MAX) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = DATA_BITS;
          serial_next  = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA_BITS: begin
        if (cnt_reg == CNT_MAX) begin
          cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next    = STOP_BIT;
            stop_idx_next = 1'b0;
            serial_next   = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
            serial_next  = shift_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP_BIT: begin
        serial_next = 1'b1;
        if (cnt_reg == CNT_MAX) begin
          cnt_next = '0;
          if (stop_idx_reg == STOP_LAST) begin
            state_next  = CLEANUP;
            done_next   = 1'b1;
            active_next = 1'b0;
          end else begin
            stop_idx_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      CLEANUP: begin
        state_next  = IDLE;
        serial_next = 1'b1;
        active_next = 1'b0;
      end

      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
        active_next = 1'b0;
      end
    endcase
  end

  assign output_serial = serial_reg;
  assign active        = active_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances with different bit periods and
// stop-bit counts, checked cycle by cycle against an arithmetic frame model.
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      start;
  logic [2:0][7:0] byte_in;
  logic [2:0]      ser, act, dn;

  int tests = 0;
  int fails = 0;

  uart_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .input_Byte(byte_in[0]),
    .output_serial(ser[0]), .active(act[0]), .done(dn[0]));

  uart_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .input_Byte(byte_in[1]),
    .output_serial(ser[1]), .active(act[1]), .done(dn[1]));

  uart_transmitter #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .input_Byte(byte_in[2]),
    .output_serial(ser[2]), .active(act[2]), .done(dn[2]));

  function automatic int cpb(input int d);
    return (d == 0) ? 1 : (d == 1) ? 4 : 3;
  endfunction

  function automatic int nstop(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge while the DUT is idle. Sends byte b, checks every
  // cycle of the frame plus the idle cycle after it. A nonzero repulse_at
  // pulses start with 0x3C at that frame cycle; hold keeps start high.
  task automatic frame(input int d, input logic [7:0] b, input int repulse_at, input bit hold);
    int c, s, len, slot;
    logic exp_ser, exp_act, exp_dn;
    logic [7:0] rx;
    c   = cpb(d);
    s   = nstop(d);
    len = (9 + s) * c + 1;
    rx  = 8'h00;
    start[d]   = 1'b1;
    byte_in[d] = b;
    @(negedge clk);
    if (!hold) start[d] = 1'b0;
    byte_in[d] = 8'($urandom);
    for (int t = 1; t <= len; t++) begin
      if (t == len) begin
        exp_ser = 1'b1; exp_act = 1'b0; exp_dn = 1'b1;
      end else begin
        slot    = (t - 1) / c;
        exp_ser = (slot == 0) ? 1'b0 : (slot <= 8) ? b[slot-1] : 1'b1;
        exp_act = 1'b1;
        exp_dn  = 1'b0;
      end
      for (int i = 0; i < 8; i++)
        if (t == 1 + (i + 1) * c + c / 2) rx[i] = ser[d];
      chk($sformatf("dut%0d byte%02h t%0d serial", d, b, t), {7'd0, ser[d]}, {7'd0, exp_ser});
      chk($sformatf("dut%0d byte%02h t%0d active", d, b, t), {7'd0, act[d]}, {7'd0, exp_act});
      chk($sformatf("dut%0d byte%02h t%0d done", d, b, t), {7'd0, dn[d]}, {7'd0, exp_dn});
      if (!hold && repulse_at != 0) begin
        if (t == repulse_at) begin
          start[d] = 1'b1; byte_in[d] = 8'h3C;
        end else if (t == repulse_at + 1) begin
          start[d] = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk($sformatf("dut%0d byte%02h loopback", d, b), rx, b);
    chk($sformatf("dut%0d byte%02h idle serial", d, b), {7'd0, ser[d]}, 8'd1);
    chk($sformatf("dut%0d byte%02h idle active", d, b), {7'd0, act[d]}, 8'd0);
    chk($sformatf("dut%0d byte%02h idle done", d, b), {7'd0, dn[d]}, 8'd0);
    if (!hold) start[d] = 1'b0;
    $display("[TB] dut%0d frame %02h repulse=%0d hold=%0d checked", d, b, repulse_at, hold);
  endtask

  initial begin
    int seen_done;
    rst     = 1'b1;
    start   = '0;
    byte_in = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset dut%0d serial", d), {7'd0, ser[d]}, 8'd1);
      chk($sformatf("reset dut%0d active", d), {7'd0, act[d]}, 8'd0);
      chk($sformatf("reset dut%0d done", d), {7'd0, dn[d]}, 8'd0);
    end

    // start together with reset must not launch a frame
    start = 3'b111;
    byte_in[0] = 8'h00; byte_in[1] = 8'h00; byte_in[2] = 8'h00;
    @(negedge clk);
    rst   = 1'b0;
    start = '0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst-vs-start dut%0d serial", d), {7'd0, ser[d]}, 8'd1);
      chk($sformatf("rst-vs-start dut%0d active", d), {7'd0, act[d]}, 8'd0);
    end
    $display("[TB] reset priority checked");

    frame(0, 8'h7F, 0, 1'b0);
    frame(1, 8'hA5, 0, 1'b0);
    frame(0, 8'h00, 0, 1'b0);
    frame(0, 8'hFF, 0, 1'b0);
    frame(0, 8'h7F, 0, 1'b0);
    frame(1, 8'hC3, 20, 1'b0);
    frame(1, 8'h5A, 41, 1'b0);
    frame(2, 8'h01, 0, 1'b1);
    frame(2, 8'h80, 0, 1'b0);

    // abort during data bit 3 of a C=4 frame
    start[1] = 1'b1; byte_in[1] = 8'h96;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort pre-reset active", {7'd0, act[1]}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort serial", {7'd0, ser[1]}, 8'd1);
    chk("abort active", {7'd0, act[1]}, 8'd0);
    chk("abort done", {7'd0, dn[1]}, 8'd0);
    seen_done = 0;
    for (int i = 0; i < 50; i++) begin
      if (dn[1] || act[1]) seen_done++;
      @(negedge clk);
    end
    chk("abort no later done/active", 8'(seen_done), 8'd0);
    $display("[TB] mid-frame reset checked");
    frame(1, 8'h55, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 3; d++) begin
        int len;
        len = (9 + nstop(d)) * cpb(d) + 1;
        frame(d, 8'($urandom), (k % 2 == 0) ? 0 : int'($urandom_range(1, len)), 1'b0);
      end
    end
    frame(2, 8'($urandom), 0, 1'b1);
    frame(2, 8'($urandom), 0, 1'b1);
    frame(2, 8'($urandom), 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1: clk cycles per serial bit; legal range 1..65535.
REQ-002 SHALL provide parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-003 SHALL provide port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port start, input, 1, request to transmit input_Byte; sampled every cycle.
REQ-006 SHALL provide port input_Byte, input, 8, byte to send; sampled only on the accepting edge.
REQ-007 SHALL provide port output_serial, output, 1, serial line; idle level 1; feeds UART_receiver input_serial.
REQ-008 SHALL provide port active, output, 1, high while a frame is on the line.
REQ-009 SHALL provide port done, output, 1, one-cycle frame-complete pulse.

Function
REQ-010 SHALL implement states IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP, all outputs registered.
REQ-011 IDLE: output_serial=1, active=0, done=0; start=1 on edge N latches input_Byte into shift register, enters START_BIT.
REQ-012 START_BIT: output_serial=0 for cycles N+1..N+C (C=CLKS_PER_BIT); active=1 from N+1.
REQ-013 DATA_BITS: 8 bits LSB first; bit i driven for C cycles starting at cycle N+1+(i+1)*C.
REQ-014 STOP_BIT: output_serial=1 for STOP_BITS*C cycles starting at N+1+9*C; active stays 1.
REQ-015 CLEANUP: exactly one cycle at N+1+(9+STOP_BITS)*C with done=1, active=0, output_serial=1; then IDLE.
REQ-016 Bit-period counter SHALL count 0..C-1 and reset on every bit boundary; C=1 gives a new bit every cycle with no skipped or repeated bit.
REQ-017 Bit index SHALL be 3 bits, advance only at data-bit boundaries, leave DATA_BITS after index 7, never wrap within a frame.
REQ-018 start SHALL be ignored outside IDLE (including CLEANUP); input_Byte changes after the accepting edge SHALL NOT affect the frame.
REQ-019 start held high continuously SHALL produce back-to-back frames separated by exactly 2 line-high cycles (CLEANUP + accepting IDLE cycle).
REQ-020 done SHALL never be high for more than one consecutive cycle and never without a completed frame.

Reset
REQ-021 rst=1 at edge SHALL force IDLE, output_serial=1, active=0, done=0, counters and shift register to 0 in the following cycle.
REQ-022 rst SHALL take priority over start; start asserted together with rst is not accepted.
REQ-023 rst mid-frame SHALL abort the frame with no done pulse; the next start after rst deasserts transmits normally.

Verification
REQ-024 C=1, input_Byte=0x7F, start pulse at N -> output_serial cycles N+1..N+10 = 0,1,1,1,1,1,1,1,0,1; done=1 only at N+11.
REQ-025 C=4, input_Byte=0xA5 -> each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1; done at N+41; active=1 for N+1..N+40.
REQ-026 Loopback into UART_receiver (C=1), bytes 0x00, 0xFF, 0x7F -> receiver output_Byte matches each byte with one done per frame.
REQ-027 start re-pulsed mid-frame with input_Byte=0x3C -> ignored; line still carries the original byte; one done only.
REQ-028 rst asserted during data bit 3 (C=4) -> next cycle output_serial=1, active=0; no done; subsequent 0x55 frame correct.
REQ-029 STOP_BITS=2, start held high, bytes 0x01 then 0x80 -> two frames, stop high for 2*C cycles, 2-cycle gap, done twice.
